mux_sel_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshakes.
//  - Mode 0: forwards only the channel chosen by sel.
//  - Mode 1: round-robin scan across all channels with valid data.
//  - Sits between multiple producer streams and a single downstream consumer.
//  - Replaces the 4x4-bit combinational selector where back-pressure and fair sharing are needed.

---
 rtl/mux_sel_rr.sv | 131 +++++++++++++
 tb/tb_mux_sel_rr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr.sv
// N-channel registered selector with valid/ready handshakes: fixed-select or round-robin.
// Optional 16-bit saturating stall counter is enabled with MUX_SEL_STALL_CNT_EN.
module mux_sel_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [SELW-1:0]        sel,
  input  logic                   mode,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_ch
`ifdef MUX_SEL_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [SELW-1:0]  grant;
  logic             grant_any;
  logic             load;
  logic [SELW-1:0]  ptr_after_grant;
  logic [WIDTH-1:0] grant_word;
  int               scan_idx;

  // Mode 1 scans upward from rr_ptr with wrap; the first valid channel wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    if (!mode) begin
      if ((int'(sel) < NCH) && in_valid[sel]) begin
        grant     = sel;
        grant_any = 1'b1;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= NCH) begin
          scan_idx = scan_idx - NCH;
        end
        if (!grant_any && in_valid[scan_idx]) begin
          grant     = SELW'(scan_idx);
          grant_any = 1'b1;
        end
      end
    end
  end

  // rst_n is folded in so no producer sees a handshake while reset is held.
  assign load = rst_n & (~out_valid_q | out_ready) & grant_any;

  assign ptr_after_grant = (int'(grant) == NCH - 1) ? '0 : grant + SELW'(1);
  assign grant_word      = in_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_data_d  = grant_word;
      out_valid_d = 1'b1;
      out_ch_d    = grant;
      if (mode) begin
        rr_ptr_d = ptr_after_grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_SEL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturates rather than wrapping so a long stall is never mistaken for a short one.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_rr.sv
// Directed self-checking bench for mux_sel_rr (WIDTH=4, NCH=4).
// Stall-counter checks are compiled in only with MUX_SEL_STALL_CNT_EN.
module tb_mux_sel_rr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
`ifdef MUX_SEL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [3:0] dat [4];
  int checks;
  int errors;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  mux_sel_rr #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_SEL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    sel       = 2'd0;
    mode      = 1'b0;
    out_ready = 1'b1;
    dat[0] = 4'h1; dat[1] = 4'h5; dat[2] = 4'hA; dat[3] = 4'hC;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 4'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (out_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_ch got %0d want 0", out_ch); end
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0000", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mode0();
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL m0_in_ready got %b want 0100", in_ready); end
    step();
    checks++;
    if (out_data !== 4'hA || out_ch !== 2'd2 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL m0_out got data=%h ch=%0d v=%b want data=a ch=2 v=1", out_data, out_ch, out_valid);
    end
    sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++; $display("[TB] FAIL m0_sel3_in_ready got %b want 1000", in_ready); end
    step();
    checks++;
    if (out_data !== 4'hC || out_ch !== 2'd3) begin
      errors++; $display("[TB] FAIL m0_sel3_out got data=%h ch=%0d want data=c ch=3", out_data, out_ch);
    end
    in_valid = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL m0_nogranted_in_ready got %b want 0000", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hC || out_ch !== 2'd3) begin
      errors++; $display("[TB] FAIL m0_pop_nogrant got v=%b data=%h ch=%0d want v=0 data=c ch=3", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_all();
    int exp_ch;
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_ch = i % 4;
      #1;
      checks++;
      if (in_ready !== 4'(1 << exp_ch)) begin
        errors++; $display("[TB] FAIL rr_all_in_ready[%0d] got %b want %b", i, in_ready, 4'(1 << exp_ch));
      end
      step();
      checks++;
      if (out_ch !== 2'(exp_ch) || out_data !== dat[exp_ch] || out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL rr_all_out[%0d] got ch=%0d data=%h v=%b want ch=%0d data=%h v=1",
                           i, out_ch, out_data, out_valid, exp_ch, dat[exp_ch]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [4] = '{1, 3, 1, 3};
    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'(1 << exp_seq[i])) begin
        errors++; $display("[TB] FAIL rr_sparse_in_ready[%0d] got %b want %b", i, in_ready, 4'(1 << exp_seq[i]));
      end
      step();
      checks++;
      if (out_ch !== 2'(exp_seq[i]) || out_data !== dat[exp_seq[i]]) begin
        errors++; $display("[TB] FAIL rr_sparse_out[%0d] got ch=%0d data=%h want ch=%0d data=%h",
                           i, out_ch, out_data, exp_seq[i], dat[exp_seq[i]]);
      end
    end
  endtask

  task automatic test_back_pressure();
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 4'h5 || out_ch !== 2'd1) begin
      errors++; $display("[TB] FAIL bp_first got data=%h ch=%0d want data=5 ch=1", out_data, out_ch);
    end
    out_ready = 1'b0;
    dat[1]    = 4'h7;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_in_ready[%0d] got %b want 0000", i, in_ready); end
      step();
      checks++;
      if (out_data !== 4'h5 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold[%0d] got data=%h ch=%0d v=%b want data=5 ch=1 v=1", i, out_data, out_ch, out_valid);
      end
    end
`ifdef MUX_SEL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("[TB] FAIL stall_cnt_5 got %0d want 5", stall_cnt); end
`endif
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release_in_ready got %b want 0010", in_ready); end
    step();
    checks++;
    if (out_data !== 4'h7 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release_out got data=%h v=%b want data=7 v=1", out_data, out_valid);
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h7) begin
      errors++; $display("[TB] FAIL bp_drain got v=%b data=%h want v=0 data=7", out_valid, out_data);
    end
    dat[1] = 4'h5;
  endtask

  task automatic test_reset_mid();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr_kept got %b want 0001", in_ready); end
    step();
    step();
    checks++;
    if (out_ch !== 2'd1 || out_data !== 4'h5) begin
      errors++; $display("[TB] FAIL mid_preload got ch=%0d data=%h want ch=1 data=5", out_ch, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL mid_reset got v=%b data=%h ch=%0d rdy=%b want v=0 data=0 ch=0 rdy=0000",
                         out_valid, out_data, out_ch, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr_reset got %b want 0001", in_ready); end
    step();
    checks++;
    if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_after got ch=%0d v=%b want ch=0 v=1", out_ch, out_valid);
    end
  endtask

`ifdef MUX_SEL_STALL_CNT_EN
  task automatic test_stall_sat();
    out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL stall_sat got %h want ffff", stall_cnt); end
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mode0();
    test_rr_all();
    test_rr_sparse();
    test_back_pressure();
    test_reset_mid();
`ifdef MUX_SEL_STALL_CNT_EN
    test_stall_sat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
